// File: rtl/modq_mul_pipe.sv
// Four-stage handshaked modular multiplier r = (a*b) mod Q with a registered Barrett reduction.
// Optional operand range correction and sticky err_range flag: define MODQ_RANGE_FIX_EN.
module modq_mul_pipe #(
  parameter int unsigned Q  = 499,
  parameter int unsigned W  = 9,
  parameter int unsigned MU = 525
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         err_range
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned MW = 3 * W + 1;
  localparam int unsigned TW = W + 2;
  localparam logic [W-1:0]  QW = W'(Q);
  localparam logic [TW-1:0] QT = TW'(Q);

  logic          advance;
  logic [W-1:0]  a_fix, b_fix;

  logic          v1, v2, v3;
  logic [W-1:0]  a1, b1;
  logic [PW-1:0] p2, p3;
  logic [W:0]    qe3;

  logic [MW-1:0] pm;
  logic [PW-1:0] qq;
  logic [TW-1:0] t0, t1, t2;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

`ifdef MODQ_RANGE_FIX_EN
  logic a_hi, b_hi;

  // W-bit operands are below 2Q, so one conditional subtract lands them in [0, Q-1].
  always_comb begin
    a_hi  = (in_a >= QW);
    b_hi  = (in_b >= QW);
    a_fix = a_hi ? (in_a - QW) : in_a;
    b_fix = b_hi ? (in_b - QW) : in_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_range <= 1'b0;
    else if (in_valid && in_ready && (a_hi || b_hi))
      err_range <= 1'b1;
  end
`else
  always_comb begin
    a_fix = in_a;
    b_fix = in_b;
  end

  assign err_range = 1'b0;
`endif

  // Barrett quotient estimate undershoots by at most 2, so t0 < 3Q fits in W+2 bits.
  always_comb begin
    pm = MW'(p2) * MW'(MU);
    qq = PW'(qe3) * PW'(Q);
    t0 = TW'(p3 - qq);
    t1 = (t0 >= QT) ? (t0 - QT) : t0;
    t2 = (t1 >= QT) ? (t1 - QT) : t1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      p2        <= '0;
      p3        <= '0;
      qe3       <= '0;
      out_r     <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      a1        <= a_fix;
      b1        <= b_fix;
      v2        <= v1;
      p2        <= PW'(a1) * PW'(b1);
      v3        <= v2;
      p3        <= p2;
      qe3       <= (W + 1)'(pm >> PW);
      out_valid <= v3;
      out_r     <= W'(t2);
    end
  end

endmodule

// File: doc/modq_mul_pipe.md
Name: modq_mul_pipe

Overview:
- Pipelined, handshaked modular multiplier: r = (a*b) mod Q, with the default prime Q=499.
- It is the producer side of the reduction path. It forms the full double-width product and runs it through an internal registered Barrett reduction.
- Reduced results go to downstream NTT/field-arithmetic consumers.
- The combinational Barrett reducers are the golden reference for the final residue.

Parameters:
- Q, 499, prime modulus; must satisfy 2^(W-1) < Q < 2^W.
- W, 9, operand and result width in bits.
- MU, floor(2^(2*W)/Q) = 525, Barrett constant; overridable, checked by the bench against the formula.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- in_a  in  W  operand a, must be < Q unless MODQ_RANGE_FIX_EN is defined
- in_b  in  W  operand b, same rule as in_a
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_r  out  W  (a*b) mod Q, always in [0, Q-1]
- err_range  out  1  sticky flag, operand >= Q seen (optional feature)

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits = 0, out_valid = 0, out_r = 0, err_range = 0, all datapath registers = 0. Reset asserted mid-operation discards every in-flight item; nothing is emitted after release until new input.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Global stall: advance = !(out_valid & !out_ready); in_ready = advance (combinational). All four stages move together only when advance = 1. On stall, every stage register, including out_r and out_valid, holds. Data and valid never change while out_valid = 1 and out_ready = 0.
- Pipeline, 4 registered stages (latency 4 cycles from accepted input to out_valid with out_ready held high, throughput 1/cycle):
  - S1: latch a, b and valid.
  - S2: p = a*b, 2W bits (max 498*498 = 248004, 18 bits).
  - S3: qe = (p*MU) >> (2W); keep p alongside.
  - S4: t = p - qe*Q, computed at W+2 bits. Since t < 3Q, subtract Q up to twice (compare-subtract chain). Register as out_r.
- Width rules: the p*MU intermediate is 2W+10 bits minimum (use 3W+1); no truncation before the shift. qe*Q is computed at 2W bits.
- Bubbles: idle slots carry valid = 0; data in bubbles is don't-care but is not allowed to affect out_r while out_valid = 1.
- Simultaneous output accept and input accept in the same cycle is legal and required for full throughput.
- No internal FSM beyond the valid shift chain. Occupancy ranges 0..4.

Optional Feature:
- Macro: MODQ_RANGE_FIX_EN.
- Defined:
  - At S1 entry, each operand >= Q is replaced by operand - Q. A single subtract suffices because 2^W < 2Q.
  - err_range is set on any accepted operand >= Q and stays set until reset.
  - Latency is unchanged.
- Undefined:
  - Operands are used as-is; err_range is tied to 0.
  - Results for operands >= Q are still exactly (a*b) mod Q only if p < 2^(2W). The four-stage path guarantees this for W-bit inputs, so the output stays correct, but no flag is raised.

Test Plan:
- Basic with out_ready = 1: a=300, b=300 -> out_r = 180 exactly 4 cycles later; a=498, b=498 -> 1; a=0, b=377 -> 0.
- Streaming: 499x499 exhaustive sweep at one pair per cycle -> every output equals (a*b)%499 in order; out_valid continuous after a 4-cycle fill.
- Backpressure: stream a=2, b=250..253 (expected results 1, 3, 5, 7), hold out_ready = 0 for 6 cycles mid-stream -> out_r/out_valid stable, in_ready = 0, no loss or duplication, ordered results resume.
- Reset mid-operation: 3 items in flight, pulse rst asynchronously between edges -> out_valid = 0 and out_r = 0 immediately; no stale results after release; next input a=100, b=5 -> 1.
- Range feature (macro defined): a=505, b=1 -> out_r = 6 and err_range = 1 (stays 1). Macro undefined: same input -> out_r = 6, err_range = 0.
- Random: 10k random pairs < 499, random in_valid/out_ready duty 50% -> scoreboard match against a Barrett reference model, zero mismatches.
